cache_arb: RTL and testbench

CACHE_ARB -- requirements
Module: cache_arb

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_rr_arb.sv | 24 ++
 rtl/cache_arb.sv | 157 +++++++++++++++
 tb/tb_cache_arb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, widths and small helpers for the two-port cache request arbiter.
package cache_pkg;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cache_req_t;

    // One-hot requester mask for a grant index.
    function automatic logic [NREQ-1:0] port_mask(input logic idx);
        port_mask = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_rr_arb.sv
// Combinational grant selection for two requesters: round-robin (ARB_MODE=0)
// or fixed priority with port 0 winning (ARB_MODE=1).
module cache_rr_arb #(
    parameter int ARB_MODE = 0
) (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pick the winner; on contention round-robin hands the grant to the port that did not win last.
    always_comb begin
        grant_valid = |req_valid;
        grant_idx   = 1'b0;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = (ARB_MODE == 1) ? 1'b0 : ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_arb.sv
// Two-requester front end to a single-ported cache: accept, issue, respond.
// Optional hit/miss counters are built when CACHE_ARB_STATS_EN is defined.
module cache_arb #(
    parameter int ARB_MODE = 0,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_hit,
    output logic                cache_read_en,
    output logic                cache_write_en,
    output logic [ADDR_W-1:0]   cache_address,
    output logic [DATA_W-1:0]   cache_write_data,
    input  logic [DATA_W-1:0]   cache_read_data,
`ifdef CACHE_ARB_STATS_EN
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses,
`endif
    input  logic                cache_hit
);

    import cache_pkg::*;

    arb_state_e          state_r;
    logic                last_grant_r;
    logic                grant_r;
    logic                wr_r;
    logic                hit_r;
    logic                rd_en_r;
    logic                wr_en_r;
    logic [1:0]          resp_valid_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                grant_valid_s;
    logic                grant_idx_s;
    logic [1:0]          req_ready_s;
    logic                sel_write_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    cache_rr_arb #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req_valid   (req_valid),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    assign sel_write_s = grant_idx_s ? req_write[1] : req_write[0];
    assign sel_addr_s  = grant_idx_s ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
    assign sel_wdata_s = grant_idx_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    // Acceptance strobe: only the winner, only while idle and out of reset.
    always_comb begin
        req_ready_s = 2'b00;
        if (!rst && (state_r == IDLE) && grant_valid_s) begin
            req_ready_s = port_mask(grant_idx_s);
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Operation sequencer; the response is captured in ISSUE so it stays stable however long RESP stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            wr_r         <= 1'b0;
            hit_r        <= 1'b0;
            rd_en_r      <= 1'b0;
            wr_en_r      <= 1'b0;
            resp_valid_r <= 2'b00;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        grant_r      <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        wr_r         <= sel_write_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        rd_en_r      <= ~sel_write_s;
                        wr_en_r      <= sel_write_s;
                        state_r      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rd_en_r      <= 1'b0;
                    wr_en_r      <= 1'b0;
                    hit_r        <= cache_hit;
                    rdata_r      <= wr_r ? {DATA_W{1'b0}} : cache_read_data;
                    resp_valid_r <= port_mask(grant_r);
                    state_r      <= RESP;
                end
                RESP: begin
                    if (resp_ready[grant_r]) begin
                        resp_valid_r <= 2'b00;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    rd_en_r      <= 1'b0;
                    wr_en_r      <= 1'b0;
                    resp_valid_r <= 2'b00;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready        = req_ready_s;
    assign resp_valid       = resp_valid_r;
    assign resp_rdata       = rdata_r;
    assign resp_hit         = hit_r;
    assign cache_read_en    = rd_en_r;
    assign cache_write_en   = wr_en_r;
    assign cache_address    = addr_r;
    assign cache_write_data = wdata_r;

`ifdef CACHE_ARB_STATS_EN
    logic [31:0] hits_r;
    logic [31:0] misses_r;

    // Saturating hit/miss counters, sampled once per cache access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_r   <= 32'd0;
            misses_r <= 32'd0;
        end else if (state_r == ISSUE) begin
            if (cache_hit) begin
                if (hits_r != 32'hFFFF_FFFF) hits_r <= hits_r + 32'd1;
            end else begin
                if (misses_r != 32'hFFFF_FFFF) misses_r <= misses_r + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_r;
    assign stat_misses = misses_r;
`endif

endmodule

// File: tb/tb_cache_arb.sv
// Self-checking bench for cache_arb: directed scenarios plus a randomized run
// against a transaction-level reference (grant rule + address->data map).
module tb_cache_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_write, resp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_hit;
    logic        cache_read_en, cache_write_en, cache_hit;
    logic [31:0] cache_address, cache_write_data, cache_read_data;
    logic [1:0]  fp_req_ready, fp_resp_valid;
    logic [31:0] fp_resp_rdata, fp_cache_address, fp_cache_write_data;
    logic        fp_resp_hit, fp_cache_read_en, fp_cache_write_en;
`ifdef CACHE_ARB_STATS_EN
    logic [31:0] stat_hits, stat_misses, fp_stat_hits, fp_stat_misses;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int last_win;
    logic [31:0] ref_mem [logic [31:0]];
    int exp_hits, exp_misses;

    always #5 clk = ~clk;

    cache_arb #(.ARB_MODE(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_hit(resp_hit), .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
        .cache_address(cache_address), .cache_write_data(cache_write_data),
        .cache_read_data(cache_read_data),
`ifdef CACHE_ARB_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
        .cache_hit(cache_hit)
    );

    cache_arb #(.ARB_MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_rdata(fp_resp_rdata),
        .resp_hit(fp_resp_hit), .cache_read_en(fp_cache_read_en),
        .cache_write_en(fp_cache_write_en), .cache_address(fp_cache_address),
        .cache_write_data(fp_cache_write_data), .cache_read_data(32'h0),
`ifdef CACHE_ARB_STATS_EN
        .stat_hits(fp_stat_hits), .stat_misses(fp_stat_misses),
`endif
        .cache_hit(1'b0)
    );

    // Simple cache responder: 64 word entries, hit if written before, miss data is a tagged pattern.
    logic        mem_clear;
    logic        mem_v [64];
    logic [31:0] mem_d [64];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem_v[i] <= 1'b0;
        end else if (cache_write_en) begin
            mem_v[cache_address[7:2]] <= 1'b1;
            mem_d[cache_address[7:2]] <= cache_write_data;
        end
    end

    always_comb begin
        cache_hit       = 1'b0;
        cache_read_data = 32'h0;
        if (cache_read_en || cache_write_en) cache_hit = mem_v[cache_address[7:2]];
        if (cache_read_en)
            cache_read_data = mem_v[cache_address[7:2]] ? mem_d[cache_address[7:2]]
                                                        : (32'hBAD0_0000 | cache_address);
    end

    function automatic int exp_winner(input logic [1:0] v, input int last, input int mode);
        if (v == 2'b00) return -1;
        if (v == 2'b11) return (mode == 1) ? 0 : ((last == 0) ? 1 : 0);
        return v[0] ? 0 : 1;
    endfunction

    function automatic logic [1:0] pmask(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1; req_valid = 2'b00;
        @(negedge clk); rst = 1'b0;
        last_win = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clear = 1'b1; req_valid = 2'b11; req_write = 2'b01;
        req_addr = {32'h44, 32'h40}; req_wdata = {32'h1, 32'h2}; resp_ready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if (req_ready !== 2'b00 || fp_req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_ready: got %b/%b expected 00", req_ready, fp_req_ready);
        end
        n_tests++;
        if (resp_valid !== 2'b00 || resp_rdata !== 32'h0 || resp_hit !== 1'b0) begin
            n_fail++; $display("FAIL reset_resp: got v=%b d=%h h=%b expected 0", resp_valid, resp_rdata, resp_hit);
        end
        n_tests++;
        if (cache_read_en !== 1'b0 || cache_write_en !== 1'b0 || cache_address !== 32'h0 || cache_write_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_cache: got re=%b we=%b a=%h d=%h expected 0", cache_read_en, cache_write_en, cache_address, cache_write_data);
        end
        rst = 1'b0; mem_clear = 1'b0; req_valid = 2'b00;
        ref_mem.delete();
        last_win = 1;
    endtask

    task automatic test_basic_read();
        @(negedge clk); req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h40}; #1;
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL read_ready: got %b expected 01", req_ready); end
        last_win = 0;
        @(negedge clk); req_valid = 2'b00; #1;
        n_tests++;
        if (cache_read_en !== 1'b1 || cache_write_en !== 1'b0 || cache_address !== 32'h40) begin
            n_fail++; $display("FAIL read_issue: got re=%b we=%b a=%h expected 1 0 40", cache_read_en, cache_write_en, cache_address);
        end
        @(negedge clk); #1;
        n_tests++;
        if (resp_valid !== 2'b01 || resp_hit !== 1'b0 || resp_rdata !== 32'hBAD0_0040) begin
            n_fail++; $display("FAIL read_resp: got v=%b h=%b d=%h expected 01 0 bad00040", resp_valid, resp_hit, resp_rdata);
        end
        @(negedge clk); #1;
        n_tests++;
        if (resp_valid !== 2'b00 || cache_read_en !== 1'b0) begin
            n_fail++; $display("FAIL read_done: got v=%b re=%b expected 00 0", resp_valid, cache_read_en);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk); req_valid = 2'b10; req_write = 2'b10;
        req_addr = {32'h40, 32'h0}; req_wdata = {32'hDEAD_BEEF, 32'h0}; #1;
        n_tests++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL wr_ready: got %b expected 10", req_ready); end
        last_win = 1;
        @(negedge clk); req_valid = 2'b00; #1;
        n_tests++;
        if (cache_write_en !== 1'b1 || cache_read_en !== 1'b0 || cache_address !== 32'h40 || cache_write_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_issue: got we=%b re=%b a=%h d=%h expected 1 0 40 deadbeef", cache_write_en, cache_read_en, cache_address, cache_write_data);
        end
        @(negedge clk); #1;
        n_tests++;
        if (resp_valid !== 2'b10 || resp_hit !== 1'b0 || resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL wr_resp: got v=%b h=%b d=%h expected 10 0 0", resp_valid, resp_hit, resp_rdata);
        end
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        @(negedge clk); req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h40}; #1;
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rd2_ready: got %b expected 01", req_ready); end
        last_win = 0;
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); #1;
        n_tests++;
        if (resp_valid !== 2'b01 || resp_hit !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd2_resp: got v=%b h=%b d=%h expected 01 1 deadbeef", resp_valid, resp_hit, resp_rdata);
        end
    endtask

    task automatic test_arbitration();
        int w;
        pulse_reset();
        req_write = 2'b00; req_addr = {32'hC0, 32'h80}; resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req_valid = 2'b11; #1;
            w = exp_winner(2'b11, last_win, 0);
            n_tests++;
            if (req_ready !== pmask(w)) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, pmask(w));
            end
            n_tests++;
            if (fp_req_ready !== pmask(exp_winner(2'b11, 0, 1))) begin
                n_fail++; $display("FAIL fp_grant%0d: got %b expected 01", k, fp_req_ready);
            end
            last_win = w;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk); #1;
                n_tests++;
                if (req_ready !== 2'b00) begin
                    n_fail++; $display("FAIL busy_ready%0d_%0d: got %b expected 00", k, c, req_ready);
                end
            end
        end
        @(negedge clk); req_valid = 2'b00;
    endtask

    task automatic test_stall();
        @(negedge clk); req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h40}; resp_ready = 2'b00; #1;
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_ready: got %b expected 01", req_ready); end
        last_win = 0;
        @(negedge clk); req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_tests++;
            if (resp_valid !== 2'b01 || resp_rdata !== ref_mem[32'h40] || resp_hit !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h h=%b expected 01 %h 1", i, resp_valid, resp_rdata, resp_hit, ref_mem[32'h40]);
            end
            n_tests++;
            if (cache_read_en !== 1'b0 || cache_write_en !== 1'b0 || req_ready !== 2'b00) begin
                n_fail++; $display("FAIL stall_quiet%0d: got re=%b we=%b rr=%b expected 0 0 00", i, cache_read_en, cache_write_en, req_ready);
            end
        end
        resp_ready = 2'b11; req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); req_valid = 2'b01; req_write = 2'b01;
        req_addr = {32'h0, 32'h44}; req_wdata = {32'h0, 32'h0000_1234}; #1;
        n_tests++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_ready: got %b expected 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        n_tests++;
        if (cache_write_en !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: got we=%b expected 1", cache_write_en); end
        rst = 1'b1; #1;
        n_tests++;
        if (cache_write_en !== 1'b0 || cache_read_en !== 1'b0 || cache_address !== 32'h0 || resp_valid !== 2'b00) begin
            n_fail++; $display("FAIL rmid_clear: got we=%b re=%b a=%h v=%b expected 0", cache_write_en, cache_read_en, cache_address, resp_valid);
        end
        @(negedge clk); req_valid = 2'b11; req_write = 2'b00; #1;
        n_tests++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            n_fail++; $display("FAIL rmid_held: got rr=%b v=%b expected 00 00", req_ready, resp_valid);
        end
        rst = 1'b0; req_valid = 2'b00; last_win = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_tests++;
            if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_noresp%0d: got %b expected 00", i, resp_valid); end
        end
        @(negedge clk); req_valid = 2'b11; req_write = 2'b00; req_addr = {32'h80, 32'h44}; #1;
        n_tests++;
        if (req_ready !== pmask(exp_winner(2'b11, last_win, 0))) begin
            n_fail++; $display("FAIL rmid_first: got %b expected 01", req_ready);
        end
        last_win = 0;
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); #1;
        n_tests++;
        if (resp_valid !== 2'b01 || resp_hit !== 1'b0 || resp_rdata !== 32'hBAD0_0044) begin
            n_fail++; $display("FAIL rmid_nowrite: got v=%b h=%b d=%h expected 01 0 bad00044", resp_valid, resp_hit, resp_rdata);
        end
    endtask

    task automatic test_random();
        logic [1:0]  v, w;
        logic [31:0] a0, a1, d0, d1, ea, ed, edata;
        logic        ew, ehit;
        int          win, stall;
        pulse_reset();
        exp_hits = 0; exp_misses = 0;
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            v  = 2'($urandom_range(0, 3)); w = 2'($urandom_range(0, 3));
            a0 = 32'h80 + 32'($urandom_range(0, 7)) * 32'd4;
            a1 = 32'h80 + 32'($urandom_range(0, 7)) * 32'd4;
            d0 = $urandom; d1 = $urandom;
            req_valid = v; req_write = w; req_addr = {a1, a0}; req_wdata = {d1, d0}; resp_ready = 2'b00;
            #1;
            win = exp_winner(v, last_win, 0);
            n_tests++;
            if (req_ready !== ((win < 0) ? 2'b00 : pmask(win))) begin
                n_fail++; $display("FAIL rnd_grant%0d: got %b valid=%b last=%0d", it, req_ready, v, last_win);
            end
            n_tests++;
            if (fp_req_ready !== ((v == 2'b00) ? 2'b00 : pmask(exp_winner(v, 0, 1)))) begin
                n_fail++; $display("FAIL rnd_fpgrant%0d: got %b valid=%b", it, fp_req_ready, v);
            end
            if (win >= 0) begin
                last_win = win;
                ew = w[win]; ea = (win == 1) ? a1 : a0; ed = (win == 1) ? d1 : d0;
                ehit = ref_mem.exists(ea);
                edata = ew ? 32'h0 : (ehit ? ref_mem[ea] : (32'hBAD0_0000 | ea));
                if (ehit) exp_hits++; else exp_misses++;
                @(negedge clk); req_valid = 2'($urandom_range(0, 3)); #1;
                n_tests++;
                if (cache_read_en !== ~ew || cache_write_en !== ew || cache_address !== ea || req_ready !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_issue%0d: got re=%b we=%b a=%h rr=%b expected wr=%b a=%h", it, cache_read_en, cache_write_en, cache_address, req_ready, ew, ea);
                end
                if (ew) begin
                    n_tests++;
                    if (cache_write_data !== ed) begin
                        n_fail++; $display("FAIL rnd_wdata%0d: got %h expected %h", it, cache_write_data, ed);
                    end
                end
                stall = $urandom_range(0, 3);
                for (int s = 0; s <= stall; s++) begin
                    @(negedge clk); #1;
                    n_tests++;
                    if (resp_valid !== pmask(win) || resp_hit !== ehit || resp_rdata !== edata) begin
                        n_fail++; $display("FAIL rnd_resp%0d_%0d: got v=%b h=%b d=%h expected %b %b %h", it, s, resp_valid, resp_hit, resp_rdata, pmask(win), ehit, edata);
                    end
                end
                resp_ready = 2'b11;
                if (ew) ref_mem[ea] = ed;
            end else begin
                n_tests++;
                if (resp_valid !== 2'b00 || cache_read_en !== 1'b0 || cache_write_en !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_idle%0d: got v=%b re=%b we=%b expected 0", it, resp_valid, cache_read_en, cache_write_en);
                end
            end
        end
        @(negedge clk); req_valid = 2'b00; resp_ready = 2'b11;
        @(negedge clk); #1;
`ifdef CACHE_ARB_STATS_EN
        n_tests++;
        if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin
            n_fail++; $display("FAIL stats: got hits=%0d misses=%0d expected %0d %0d", stat_hits, stat_misses, exp_hits, exp_misses);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_read();
        test_arbitration();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
